pb_mailbox: RTL and testbench
=============================

PB_MAILBOX -- requirements
Module: pb_mailbox

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent byte channels, legal range 1..4.
REQ-002 Parameter DEPTH, default 4: FIFO entries per channel, a power of two in the range 2..16.
REQ-003 Parameter PORT_BASE, default 4'hC: block is selected when port_id[7:4] == PORT_BASE.
REQ-004 Parameter XOR_EN, default 1: 1 enables the key-XOR ports, 0 makes them read 0x00 and ignores writes to them.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 p_port_id  in  8  producer port address.
REQ-008 p_out_port  in  8  producer write data.
REQ-009 p_write_strobe  in  1  producer write qualifier.
REQ-010 p_in_port  out  8  producer read data, which is the producer status.
REQ-011 c_port_id  in  8  consumer port address.
REQ-012 c_out_port  in  8  consumer write data.
REQ-013 c_write_strobe  in  1  consumer write qualifier.
REQ-014 c_read_strobe  in  1  consumer read qualifier.
REQ-015 c_in_port  out  8  consumer read data, registered.

Function
REQ-016 Address map (low nibble of port_id, block selected):
- 0x0+ch: data channel ch.
- 0x4+ch: XOR port ch.
- 0x8: status.
- Any other low nibble, and any ch >= CHANNELS: reads 0x00, writes ignored.
REQ-017 Producer push: p_write_strobe high with p_port_id = base|ch writes p_out_port at the tail of FIFO ch in the same edge.
REQ-018 Push to a full FIFO: data dropped; sticky ovf[ch] set.
REQ-019 Exception: a push to a full FIFO coinciding with a consumer pop on the same channel is accepted.
REQ-020 Consumer pop: c_read_strobe high with c_port_id = base|ch removes the head entry of FIFO ch.
REQ-021 Pop from an empty FIFO: no state change except setting sticky unf[ch].
REQ-022 c_in_port updates every clock from the current c_port_id decode, giving one-cycle latency.
REQ-023 For a data address, c_in_port holds the head entry, or 0x00 when empty; the value is valid before the pop edge.
REQ-024 XOR write: c_write_strobe high with c_port_id = base|0x4+ch pops FIFO ch and loads xres[ch] = c_out_port ^ head.
REQ-025 XOR write when FIFO ch is empty: xres[ch] = c_out_port unchanged; unf[ch] set.
REQ-026 Reading base|0x4+ch returns xres[ch] and has no side effect.
REQ-027 Consumer status byte: bits[3:0] = not-empty[ch], bits[5:4] = OR of all ovf / OR of all unf, bits[7:6] = 0.
REQ-028 A c_read_strobe at base|0x8 clears all ovf and unf flags after the status byte is captured.
REQ-029 If a flag is set in the same cycle as the clear, the flag stays set.
REQ-030 p_in_port (combinational from p_port_id): bits[3:0] = full[ch], bits[7:4] = 0 when address base|0x8, else 0x00.
REQ-031 Simultaneous push and pop on the same channel: both take effect, count unchanged; when empty, the pop underflows and the push succeeds.
REQ-032 Pointers wrap modulo DEPTH; each count ranges 0..DEPTH with full = (count == DEPTH).
REQ-033 Unused channel bits (ch >= CHANNELS) in all status bytes read 0.

Reset
REQ-034 On reset_n low, immediately and regardless of clk, clear all of: pointers, counts, ovf, unf, xres, and c_in_port (to 0x00).
REQ-035 Release of reset_n takes effect synchronously; the first accepted strobe is on the first rising clk edge with reset_n high.
REQ-036 Reset asserted mid-transfer discards FIFO contents; no partial push or pop completes.

Verification
REQ-037 Push 0xA5 then 0x3C on ch0, then two consumer reads of 0xC0 -> c_in_port returns 0xA5 then 0x3C; status then reads 0x00.
REQ-038 DEPTH=4: push five bytes 0x01..0x05 on ch1 -> p_in_port at 0xC8 reads 0x02 after the fourth push; consumer status reads 0x12; four reads return 0x01..0x04; a second status read returns 0x00.
REQ-039 Push key 0x5A on ch0, consumer writes 0x48 to 0xC4 -> read of 0xC4 returns 0x12; ch0 is empty afterwards.
REQ-040 On empty ch1: read 0xC1 -> 0x00 with status bit5 set; XOR write of 0x77 to 0xC5 -> reading 0xC5 returns 0x77.
REQ-041 ch0 full with DEPTH=4: push 0x99 and pop in the same cycle -> pop returns the oldest entry, count stays 4, and 0x99 is last out.
REQ-042 Pulse reset_n low between clock edges with ch0 holding 3 entries -> c_in_port is 0x00 before the next edge; status reads 0x00 after release.

Source files
------------

// File: rtl/pb_mailbox.sv
// Producer-to-consumer byte mailbox for two PicoBlaze-style port buses.
// One FIFO per channel, sticky overflow/underflow flags, and a key-XOR read-modify port.
module pb_mailbox #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  PORT_BASE = 4'hC,
    parameter bit          XOR_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] p_port_id,
    input  logic [7:0] p_out_port,
    input  logic       p_write_strobe,
    output logic [7:0] p_in_port,
    input  logic [7:0] c_port_id,
    input  logic [7:0] c_out_port,
    input  logic       c_write_strobe,
    input  logic       c_read_strobe,
    output logic [7:0] c_in_port
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // NOTE: the storage array has no reset; clearing the pointers and counts is
    // enough to discard its contents, and keeping it reset-free lets it map to RAM.
    logic [7:0]       mem_q    [CHANNELS][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_q [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q    [CHANNELS];
    logic [CNT_W-1:0] cnt_d    [CHANNELS];
    logic [7:0]       xres_q   [CHANNELS];
    logic [7:0]       xres_d   [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] unf_q, unf_d;
    logic [7:0]       c_in_q, c_in_d;

    logic [7:0]          head [CHANNELS];
    logic [CHANNELS-1:0] empty, full;
    logic [CHANNELS-1:0] push_req, push_ok, pop_req, pop_ok, x_pop;

    logic       p_sel, c_sel;
    logic [3:0] p_lo, c_lo;
    logic       status_clr;
    logic [7:0] status;
    logic [3:0] full_bits;

    assign p_sel      = (p_port_id[7:4] == PORT_BASE);
    assign c_sel      = (c_port_id[7:4] == PORT_BASE);
    assign p_lo       = p_port_id[3:0];
    assign c_lo       = c_port_id[3:0];
    assign status_clr = c_read_strobe && c_sel && (c_lo == 4'h8);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path can leave it unassigned (no latches).
    always_comb begin
        push_req = '0;
        pop_req  = '0;
        pop_ok   = '0;
        push_ok  = '0;
        x_pop    = '0;
        empty    = '0;
        full     = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            head[ch]     = mem_q[ch][rd_ptr_q[ch]];
            empty[ch]    = (cnt_q[ch] == '0);
            full[ch]     = (cnt_q[ch] == CNT_W'(DEPTH));
            push_req[ch] = p_write_strobe && p_sel && (p_lo == 4'(ch));
            x_pop[ch]    = XOR_EN && c_write_strobe && c_sel && (c_lo == 4'(ch + 4));
            pop_req[ch]  = (c_read_strobe && c_sel && (c_lo == 4'(ch))) || x_pop[ch];
            pop_ok[ch]   = pop_req[ch] && !empty[ch];
            // A successful pop frees the slot this edge, so a push to a full FIFO still lands.
            push_ok[ch]  = push_req[ch] && (!full[ch] || pop_ok[ch]);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        xres_d   = xres_q;
        // Clear happens first so that a flag raised in the same cycle survives it.
        ovf_d    = status_clr ? '0 : ovf_q;
        unf_d    = status_clr ? '0 : unf_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (pop_ok[ch]) begin
                rd_ptr_d[ch] = rd_ptr_q[ch] + PTR_W'(1);
            end
            if (push_ok[ch]) begin
                wr_ptr_d[ch] = wr_ptr_q[ch] + PTR_W'(1);
            end
            cnt_d[ch] = cnt_q[ch] + CNT_W'(push_ok[ch]) - CNT_W'(pop_ok[ch]);
            if (push_req[ch] && !push_ok[ch]) begin
                ovf_d[ch] = 1'b1;
            end
            if (pop_req[ch] && empty[ch]) begin
                unf_d[ch] = 1'b1;
            end
            if (x_pop[ch]) begin
                xres_d[ch] = empty[ch] ? c_out_port : (c_out_port ^ head[ch]);
            end
        end
    end

    always_comb begin
        status    = '0;
        full_bits = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            status[ch]    = !empty[ch];
            full_bits[ch] = full[ch];
        end
        status[4] = |ovf_q;
        status[5] = |unf_q;

        // Read data reflects the state before this edge, so a pop returns the old head.
        c_in_d = 8'h00;
        if (c_sel) begin
            if (c_lo == 4'h8) begin
                c_in_d = status;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if ((c_lo == 4'(ch)) && !empty[ch]) begin
                    c_in_d = head[ch];
                end
                if (XOR_EN && (c_lo == 4'(ch + 4))) begin
                    c_in_d = xres_q[ch];
                end
            end
        end

        p_in_port = (p_sel && (p_lo == 4'h8)) ? {4'h0, full_bits} : 8'h00;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                wr_ptr_q[ch] <= '0;
                rd_ptr_q[ch] <= '0;
                cnt_q[ch]    <= '0;
                xres_q[ch]   <= 8'h00;
            end
            ovf_q  <= '0;
            unf_q  <= '0;
            c_in_q <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            xres_q   <= xres_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            c_in_q   <= c_in_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (push_ok[ch]) begin
                mem_q[ch][wr_ptr_q[ch]] <= p_out_port;
            end
        end
    end

    assign c_in_port = c_in_q;

endmodule

// File: tb/tb_pb_mailbox.sv
// Self-checking bench for pb_mailbox: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model of the mailbox.
module tb_pb_mailbox;

    localparam int CH  = 2;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] p_port_id = 8'h00;
    logic [7:0] p_out_port = 8'h00;
    logic       p_write_strobe = 1'b0;
    logic [7:0] p_in_port;
    logic [7:0] c_port_id = 8'h00;
    logic [7:0] c_out_port = 8'h00;
    logic       c_write_strobe = 1'b0;
    logic       c_read_strobe = 1'b0;
    logic [7:0] c_in_port;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pb_mailbox #(
        .CHANNELS (CH),
        .DEPTH    (DEP),
        .PORT_BASE(4'hC),
        .XOR_EN   (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .p_port_id     (p_port_id),
        .p_out_port    (p_out_port),
        .p_write_strobe(p_write_strobe),
        .p_in_port     (p_in_port),
        .c_port_id     (c_port_id),
        .c_out_port    (c_out_port),
        .c_write_strobe(c_write_strobe),
        .c_read_strobe (c_read_strobe),
        .c_in_port     (c_in_port)
    );

    always #5 clk = ~clk;

    // Behavioural model: one byte queue per channel plus flags and XOR results.
    logic [7:0]    mq [CH][$];
    logic [CH-1:0] m_ovf;
    logic [CH-1:0] m_unf;
    logic [7:0]    m_xres [CH];

    logic [7:0] p_addrs [6] = '{8'hC0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0};
    logic [7:0] c_addrs [9] = '{8'hC0, 8'hC1, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC8, 8'hC9, 8'hB0};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int ch = 0; ch < CH; ch++) begin
            mq[ch].delete();
            m_xres[ch] = 8'h00;
        end
        m_ovf = '0;
        m_unf = '0;
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s = 8'h00;
        for (int ch = 0; ch < CH; ch++) s[ch] = (mq[ch].size() != 0);
        s[4] = |m_ovf;
        s[5] = |m_unf;
        return s;
    endfunction

    function automatic logic [7:0] m_cread(input logic [7:0] a);
        int lo = int'(a[3:0]);
        if (a[7:4] != 4'hC) return 8'h00;
        if (lo < CH) return (mq[lo].size() != 0) ? mq[lo][0] : 8'h00;
        if (lo >= 4 && lo < 4 + CH) return m_xres[lo - 4];
        if (lo == 8) return m_status();
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_pread(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        if (a != 8'hC8) return 8'h00;
        for (int ch = 0; ch < CH; ch++) v[ch] = (mq[ch].size() == DEP);
        return v;
    endfunction

    task automatic m_update(input logic [7:0] pa, input logic [7:0] pd, input logic pw,
                            input logic [7:0] ca, input logic [7:0] cd, input logic cw,
                            input logic cr);
        logic [7:0] h;
        logic       rd_hit, x_hit;
        if (cr && ca == 8'hC8) begin
            m_ovf = '0;
            m_unf = '0;
        end
        for (int ch = 0; ch < CH; ch++) begin
            rd_hit = cr && (ca == (8'hC0 + 8'(ch)));
            x_hit  = cw && (ca == (8'hC4 + 8'(ch)));
            if (rd_hit || x_hit) begin
                if (mq[ch].size() == 0) begin
                    m_unf[ch] = 1'b1;
                    if (x_hit) m_xres[ch] = cd;
                end else begin
                    h = mq[ch].pop_front();
                    if (x_hit) m_xres[ch] = cd ^ h;
                end
            end
            if (pw && pa == (8'hC0 + 8'(ch))) begin
                if (mq[ch].size() < DEP) mq[ch].push_back(pd);
                else m_ovf[ch] = 1'b1;
            end
        end
    endtask

    // One bus cycle: drive at negedge, check producer status, then check the registered read.
    task automatic step(input logic [7:0] pa, input logic [7:0] pd, input logic pw,
                        input logic [7:0] ca, input logic [7:0] cd, input logic cw,
                        input logic cr, input string tag);
        logic [7:0] exp_c;
        @(negedge clk);
        p_port_id      = pa;
        p_out_port     = pd;
        p_write_strobe = pw;
        c_port_id      = ca;
        c_out_port     = cd;
        c_write_strobe = cw;
        c_read_strobe  = cr;
        #1;
        check({tag, "/p_in"}, p_in_port, m_pread(pa));
        exp_c = m_cread(ca);
        m_update(pa, pd, pw, ca, cd, cw, cr);
        @(posedge clk);
        #1;
        check({tag, "/c_in"}, c_in_port, exp_c);
    endtask

    task automatic push(input logic [7:0] pa, input logic [7:0] d, input string tag);
        step(pa, d, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic cread(input logic [7:0] ca, input string tag);
        step(8'h00, 8'h00, 1'b0, ca, 8'h00, 1'b0, 1'b1, tag);
    endtask

    task automatic cwrite(input logic [7:0] ca, input logic [7:0] d, input string tag);
        step(8'h00, 8'h00, 1'b0, ca, d, 1'b1, 1'b0, tag);
    endtask

    task automatic idle(input logic [7:0] pa, input logic [7:0] ca, input string tag);
        step(pa, 8'h00, 1'b0, ca, 8'h00, 1'b0, 1'b0, tag);
    endtask

    initial begin
        m_reset();
        p_port_id = 8'hC8;
        c_port_id = 8'hC8;
        #2;
        check("rst_c_in", c_in_port, 8'h00);
        check("rst_p_in", p_in_port, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic push then two reads on ch0.
        push(8'hC0, 8'hA5, "r37_push0");
        push(8'hC0, 8'h3C, "r37_push1");
        cread(8'hC0, "r37_rd0");
        check("r37_val0", c_in_port, 8'hA5);
        cread(8'hC0, "r37_rd1");
        check("r37_val1", c_in_port, 8'h3C);
        idle(8'h00, 8'hC8, "r37_stat");
        check("r37_status", c_in_port, 8'h00);

        // Overflow on ch1 and status clear.
        for (int i = 1; i <= 4; i++) push(8'hC1, 8'(i), "r38_push");
        idle(8'hC8, 8'h00, "r38_full");
        check("r38_full_c8", p_in_port, 8'h02);
        push(8'hC1, 8'h05, "r38_ovf");
        cread(8'hC8, "r38_stat");
        check("r38_status", c_in_port, 8'h12);
        for (int i = 1; i <= 4; i++) begin
            cread(8'hC1, "r38_rd");
            check("r38_val", c_in_port, 8'(i));
        end
        cread(8'hC8, "r38_stat2");
        check("r38_status2", c_in_port, 8'h00);

        // Key XOR with a queued key.
        push(8'hC0, 8'h5A, "r39_push");
        cwrite(8'hC4, 8'h48, "r39_xor");
        idle(8'h00, 8'hC4, "r39_rdx");
        check("r39_xres", c_in_port, 8'h12);
        idle(8'h00, 8'hC8, "r39_stat");
        check("r39_empty", c_in_port, 8'h00);

        // Underflow read and XOR on an empty channel.
        cread(8'hC1, "r40_rd");
        check("r40_val", c_in_port, 8'h00);
        idle(8'h00, 8'hC8, "r40_stat");
        check("r40_unf", c_in_port, 8'h20);
        cwrite(8'hC5, 8'h77, "r40_xor");
        idle(8'h00, 8'hC5, "r40_rdx");
        check("r40_xres", c_in_port, 8'h77);
        cread(8'hC8, "r40_clr");

        // Full FIFO with simultaneous push and pop.
        push(8'hC0, 8'h11, "r41_p");
        push(8'hC0, 8'h22, "r41_p");
        push(8'hC0, 8'h33, "r41_p");
        push(8'hC0, 8'h44, "r41_p");
        step(8'hC0, 8'h99, 1'b1, 8'hC0, 8'h00, 1'b0, 1'b1, "r41_both");
        check("r41_oldest", c_in_port, 8'h11);
        idle(8'hC8, 8'h00, "r41_full");
        check("r41_still_full", p_in_port, 8'h01);
        cread(8'hC0, "r41_rd");
        check("r41_v1", c_in_port, 8'h22);
        cread(8'hC0, "r41_rd");
        cread(8'hC0, "r41_rd");
        cread(8'hC0, "r41_rd");
        check("r41_last", c_in_port, 8'h99);
        cread(8'hC8, "r41_stat");
        check("r41_no_ovf", c_in_port, 8'h00);

        // Empty FIFO with simultaneous push and pop: pop underflows, push lands.
        step(8'hC0, 8'h55, 1'b1, 8'hC0, 8'h00, 1'b0, 1'b1, "both_empty");
        idle(8'h00, 8'hC8, "both_empty_stat");
        check("both_empty_status", c_in_port, 8'h21);
        cread(8'hC8, "both_empty_clr");
        cread(8'hC0, "both_empty_drain");
        check("both_empty_val", c_in_port, 8'h55);

        // Flag raised in the same cycle as the status clear survives.
        for (int i = 0; i < 4; i++) push(8'hC1, 8'hE0 + 8'(i), "clr_fill");
        step(8'hC1, 8'hAA, 1'b1, 8'hC8, 8'h00, 1'b0, 1'b1, "clr_ovf");
        check("clr_ovf_pre", c_in_port, 8'h02);
        idle(8'h00, 8'hC8, "clr_ovf_post");
        check("clr_ovf_kept", c_in_port, 8'h12);
        cread(8'hC8, "clr_ovf_clr");
        for (int i = 0; i < 4; i++) cread(8'hC1, "clr_drain");

        // Asynchronous reset pulse between edges.
        push(8'hC0, 8'h01, "r42_p");
        push(8'hC0, 8'h02, "r42_p");
        push(8'hC0, 8'h03, "r42_p");
        idle(8'h00, 8'hC0, "r42_head");
        check("r42_head_val", c_in_port, 8'h01);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("r42_async", c_in_port, 8'h00);
        m_reset();
        #1 reset_n = 1'b1;
        idle(8'h00, 8'hC8, "r42_stat");
        check("r42_status", c_in_port, 8'h00);
        idle(8'h00, 8'hC0, "r42_empty");
        check("r42_ch0_empty", c_in_port, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(p_addrs[$urandom_range(5)], 8'($urandom), ($urandom_range(2) != 0),
                 c_addrs[$urandom_range(8)], 8'($urandom), ($urandom_range(3) == 0),
                 ($urandom_range(1) == 0), "rand");
        end
        idle(8'h00, 8'h00, "final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
